// File: rtl/riscv_32_fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, issues one imem read at a time and
// buffers the returned word for the decoder behind a valid/ready handshake.
module riscv_32_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic [31:0] instr_nxt, instr_pc_nxt;
  logic        fault_nxt;
  logic        redir_ok, redir_bad;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign imem_addr = pc;

  // Next-state, PC and buffer update; aligned redirects override the normal flow.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    kill_nxt     = kill;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    fault_nxt    = fetch_fault;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redir_ok) pc_nxt = redirect_pc;
      end
      S_REQ: begin
        state_nxt = S_WAIT;
        if (redir_ok) begin
          pc_nxt   = redirect_pc;
          kill_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (redir_ok) begin
          pc_nxt = redirect_pc;
          if (imem_rvalid) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            kill_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            instr_nxt    = imem_rdata;
            instr_pc_nxt = pc;
            pc_nxt       = pc + 32'd4;
            state_nxt    = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redir_ok) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (instr_ready) begin
          state_nxt = S_REQ;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
    // A misaligned target halts fetching until reset.
    if ((state != S_FAULT) && redir_bad) begin
      state_nxt = S_FAULT;
      fault_nxt = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_pc    <= RESET_PC;
      fetch_fault <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      kill        <= kill_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      fetch_fault <= fault_nxt;
      imem_req    <= (state_nxt == S_REQ);
      instr_valid <= (state_nxt == S_OUT);
    end
  end

endmodule

// File: tb/tb_riscv_32_fetch_unit.sv
// Bench for riscv_32_fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level program-order scoreboard.
module tb_riscv_32_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;

  int n_checks = 0;
  int n_err    = 0;
  int n_deliv  = 0;
  int mem_lat  = 1;
  bit mem_rand = 1'b0;

  riscv_32_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0033 + ((a - 32'h0000_0100) << 5);
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req) found = 1'b1;
    end
    if (!found) check32({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    if (!found) check32({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Instruction memory: one response per observed request after mem_lat cycles.
  initial begin
    logic [31:0] a;
    int l;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        a = imem_addr;
        l = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        repeat (l) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard: delivered instructions must follow program order from the last redirect.
  initial begin
    logic [31:0] exp_pc, hold_pc, hold_instr;
    bit m_fault, prev_req, prev_hold;
    exp_pc = RPC; m_fault = 0; prev_req = 0; prev_hold = 0;
    hold_pc = 0; hold_instr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc = RPC; m_fault = 0; prev_req = 0; prev_hold = 0;
      end else begin
        if (prev_req) check32("req_pulse", 32'(imem_req), 32'd0);
        if (prev_hold) begin
          check32("hold_valid", 32'(instr_valid), 32'd1);
          check32("hold_pc", instr_pc, hold_pc);
          check32("hold_instr", instr, hold_instr);
        end
        if (instr_valid) check32("req_while_valid", 32'(imem_req), 32'd0);
        if (m_fault) begin
          check32("fault_flag", 32'(fetch_fault), 32'd1);
          check32("fault_req", 32'(imem_req), 32'd0);
          check32("fault_valid", 32'(instr_valid), 32'd0);
        end else begin
          check32("no_fault", 32'(fetch_fault), 32'd0);
          if (imem_req) check32("req_addr", imem_addr, exp_pc);
          if (instr_valid && instr_ready) begin
            check32("deliv_pc", instr_pc, exp_pc);
            check32("deliv_instr", instr, mem_word(exp_pc));
            n_deliv++;
            exp_pc = exp_pc + 32'd4;
          end
          if (redirect_valid) begin
            if (redirect_pc[1:0] == 2'b00) exp_pc = redirect_pc;
            else m_fault = 1'b1;
          end
        end
        prev_req   = imem_req;
        prev_hold  = instr_valid && !instr_ready && !redirect_valid;
        hold_pc    = instr_pc;
        hold_instr = instr;
      end
    end
  end

  initial begin
    int nd0;
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_addr", imem_addr, RPC);
    check32("rst_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_pc", instr_pc, RPC);
    check32("rst_fault", 32'(fetch_fault), 32'd0);

    // Reset fetch: REQ, WAIT, OUT cadence from RESET_PC
    adv(); rst = 1'b0;
    @(negedge clk);
    check32("idle_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check32("seq_req", 32'(imem_req), 32'((i % 3) == 0));
      check32("seq_valid", 32'(instr_valid), 32'((i % 3) == 2));
      if ((i % 3) == 0) check32("seq_addr", imem_addr, RPC + 32'(4 * (i / 3)));
      if ((i % 3) == 2) begin
        check32("seq_pc", instr_pc, RPC + 32'(4 * (i / 3)));
        check32("seq_instr", instr, mem_word(RPC + 32'(4 * (i / 3))));
      end
    end

    // Redirect one cycle after REQ with 3-cycle memory
    mem_lat = 3;
    wait_req("rw_req");
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    adv(); redirect_valid = 1'b0;
    wait_req("rw_req2");
    check32("rw_addr", imem_addr, 32'h200);
    wait_valid("rw_valid");
    check32("rw_pc", instr_pc, 32'h200);
    check32("rw_instr", instr, mem_word(32'h200));

    // Redirect coincident with imem_rvalid
    mem_lat = 2;
    wait_req("rv_req");
    adv(); adv(); redirect_valid = 1'b1; redirect_pc = 32'h300;
    adv(); redirect_valid = 1'b0;
    @(negedge clk);
    check32("rv_req_now", 32'(imem_req), 32'd1);
    check32("rv_addr", imem_addr, 32'h300);
    wait_valid("rv_valid");
    check32("rv_pc", instr_pc, 32'h300);

    // Redirect coincident with an OUT handshake
    mem_lat = 1;
    wait_req("hs_req");
    adv(); adv(); redirect_valid = 1'b1; redirect_pc = 32'h400; nd0 = n_deliv;
    @(negedge clk);
    check32("hs_valid", 32'(instr_valid), 32'd1);
    adv(); redirect_valid = 1'b0;
    @(negedge clk);
    check32("hs_valid_drop", 32'(instr_valid), 32'd0);
    check32("hs_req_now", 32'(imem_req), 32'd1);
    check32("hs_addr", imem_addr, 32'h400);
    check32("hs_once", 32'(n_deliv - nd0), 32'd1);

    // PC wrap
    wait_req("wr_req");
    adv(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    adv(); redirect_valid = 1'b0;
    wait_req("wr_req2");
    check32("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    wait_req("wr_req3");
    check32("wr_addr1", imem_addr, 32'h0000_0000);

    // Backpressure: buffer held for 5 cycles, one handshake, then pc + 4
    adv(); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
    adv(); redirect_valid = 1'b0;
    wait_valid("bp_valid");
    check32("bp_pc", instr_pc, 32'h500);
    check32("bp_instr", instr, mem_word(32'h500));
    for (int i = 0; i < 5; i++) begin
      adv();
      @(negedge clk);
      check32("bp_hold_valid", 32'(instr_valid), 32'd1);
      check32("bp_hold_req", 32'(imem_req), 32'd0);
      check32("bp_hold_pc", instr_pc, 32'h500);
    end
    nd0 = n_deliv;
    adv(); instr_ready = 1'b1;
    adv(); instr_ready = 1'b0;
    wait_req("bp_req");
    check32("bp_addr", imem_addr, 32'h504);
    check32("bp_once", 32'(n_deliv - nd0), 32'd1);
    instr_ready = 1'b1;

    // Randomized traffic
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      adv();
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF8;
      else redirect_pc = {20'h0, 10'($urandom), 2'b00};
    end
    adv(); redirect_valid = 1'b0; instr_ready = 1'b1; mem_rand = 1'b0;
    check32("deliv_min", 32'(n_deliv >= 100), 32'd1);

    // Misaligned redirect: sticky fault, no requests until reset
    mem_lat = 2;
    wait_req("ft_req");
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h202;
    adv(); redirect_valid = 1'b0;
    @(negedge clk);
    check32("ft_flag", 32'(fetch_fault), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check32("ft_no_req", 32'(imem_req), 32'd0);
    end
    adv(); rst = 1'b1;
    adv();
    @(negedge clk);
    check32("ft_cleared", 32'(fetch_fault), 32'd0);
    adv(); rst = 1'b0;

    // Reset mid-fetch with the response landing during reset
    mem_lat = 3;
    wait_req("rm_req");
    adv(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adv();
      @(negedge clk);
      check32("rm_valid", 32'(instr_valid), 32'd0);
      check32("rm_req", 32'(imem_req), 32'd0);
    end
    adv(); rst = 1'b0;
    wait_req("rm_req2");
    check32("rm_addr", imem_addr, RPC);
    wait_valid("rm_valid2");
    check32("rm_pc", instr_pc, RPC);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_32_fetch_unit.md
# riscv_32_fetch_unit

Instruction fetch stage of the RV32 multi-cycle CPU, directly upstream of `riscv_32_instr_decoder`. It owns the program counter and issues one word-aligned read at a time to instruction memory. Each returned instruction is held in a one-entry output buffer, with its PC, until the decoder accepts it through a valid/ready handshake. Branch/jump redirects from the control unit flush any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; must be word-aligned.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `imem_req`, output, 1: read request to instruction memory; high for exactly one cycle per fetch.
- `imem_addr`, output, 32: fetch address; valid while `imem_req` = 1.
- `imem_rvalid`, input, 1: read data valid; arrives 1 or more cycles after `imem_req`.
- `imem_rdata`, input, 32: instruction word; sampled when `imem_rvalid` = 1.
- `redirect_valid`, input, 1: one-cycle pulse from the control unit requesting a new fetch PC.
- `redirect_pc`, input, 32: new fetch PC; sampled when `redirect_valid` = 1.
- `instr_valid`, output, 1: `instr` and `instr_pc` hold an instruction for the decoder.
- `instr`, output, 32: instruction word; drives the decoder's `full` input.
- `instr_pc`, output, 32: address of `instr`.
- `instr_ready`, input, 1: decoder accepts `instr` this cycle.
- `fetch_fault`, output, 1: sticky flag for a misaligned redirect; fetching halts.

## Operation
- **FSM states:**
  - IDLE: reset state. Moves to REQ on the next cycle with `rst` = 0.
  - REQ: `imem_req` = 1 and `imem_addr` = pc. Always moves to WAIT.
  - WAIT: waits for `imem_rvalid`.
  - OUT: `instr_valid` = 1.
  - FAULT: absorbing until reset.
- **WAIT, on `imem_rvalid`:**
  - kill = 0: load `instr` = `imem_rdata` and `instr_pc` = pc, set pc = pc + 4, go to OUT.
  - kill = 1: discard the data, clear kill, go to REQ.
- **OUT:** when `instr_ready` = 1, the handshake completes, `instr_valid` drops the next cycle, and the FSM goes to REQ. `instr` and `instr_pc` are held stable while `instr_valid` = 1 and `instr_ready` = 0.
- **Only one request is ever outstanding.** `imem_rvalid` outside WAIT is ignored.
- **PC arithmetic:** 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- **Redirect with `redirect_pc[1:0]` = 0 takes priority over all other transitions.** pc is loaded with `redirect_pc` in every state except FAULT.
  - Redirect in REQ: the request at the old pc still issues; kill is set; the FSM goes to WAIT.
  - Redirect in WAIT, no `imem_rvalid`: kill is set; the FSM stays in WAIT.
  - Redirect in WAIT with `imem_rvalid` in the same cycle: the response is discarded; the FSM goes to REQ.
  - Redirect in OUT: the buffer is flushed (`instr_valid` drops next cycle); the FSM goes to REQ. A handshake in the same cycle still counts as consumed.
  - Redirect in IDLE: pc = `redirect_pc`; the FSM goes to REQ.
- **Redirect with `redirect_pc[1:0]` ≠ 0:**
  - `fetch_fault` is set to 1 and the FSM enters FAULT.
  - In FAULT: `imem_req` = 0 and `instr_valid` = 0; pc is unchanged. A pending response is ignored.
- **Reset:** `rst` forces IDLE in any state, including mid-fetch. kill is cleared, and any response arriving after reset is ignored until the next REQ.

## Timing
- **Reset values** (every output):
  - `imem_req` = 0.
  - `imem_addr` = `RESET_PC`.
  - `instr_valid` = 0.
  - `instr` = 32'h0000_0000.
  - `instr_pc` = `RESET_PC`.
  - `fetch_fault` = 0.
  - Internal: pc = `RESET_PC`, kill = 0.
- **First request:** `rst` falls before edge k. IDLE is left at edge k, and `imem_req` is high in the cycle after edge k.
- **Per-fetch latency:** `instr_valid` rises on the edge after the `imem_rvalid` cycle. With 1-cycle memory, the sequence is REQ, WAIT, OUT.
- **Best-case throughput:** one instruction per 3 cycles (`instr_ready` tied high, 1-cycle memory).
- **Output timing:** all outputs are registered or decoded from state; no combinational path from inputs to outputs.

## Test plan
- **Reset fetch:** `RESET_PC` = 32'h100, 1-cycle memory returning 32'h0000_0033, `instr_ready` tied 1 → `imem_addr` sequence 0x100, 0x104, 0x108; `instr_valid` pulses 1 cycle every 3; `instr_pc` = 0x100 with `instr` = 32'h0000_0033 first.
- **Backpressure:** `instr_ready` = 0 for 5 cycles while in OUT → `instr` and `instr_pc` stable and `imem_req` = 0 throughout; a single handshake on `instr_ready` = 1, then the next REQ at pc + 4.
- **Redirect in WAIT:** 3-cycle memory, redirect to 0x200 one cycle after REQ → the stale word is discarded and never shown on `instr_valid`; the next `imem_addr` = 0x200; the delivered `instr_pc` = 0x200.
- **Simultaneous events:** redirect coincident with `imem_rvalid`, and separately with an OUT handshake → the response is dropped in the first case and the instruction is consumed exactly once in the second; both then fetch from `redirect_pc`.
- **Wrap and fault:**
  - Redirect to 32'hFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
  - Redirect to 0x202 → `fetch_fault` = 1; no further `imem_req` until `rst`, which clears the fault.
- **Reset mid-fetch:** `rst` asserted in WAIT, with `imem_rvalid` arriving during reset → no `instr_valid`; after release, the first `imem_addr` = `RESET_PC`.
